shift_reg_sequencer: RTL and testbench

- Controller for a WIDTH-bit bidirectional shift register with ports mode/Dr/Dl/q.
- Accepts a parallel word and a direction on a valid/ready handshake.
- Drives the register's mode and serial inputs for exactly WIDTH clocks so that q equals the word, then captures q and pulses done.
- Sits between a host and the register; the register has no hold/enable, so this block owns every cycle of its inputs.

---
 rtl/srctrl_pkg.sv | 32 +++
 rtl/shift_reg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_shift_reg_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/srctrl_pkg.sv
// ============================================================================
//  Package     : srctrl_pkg
//  Description : Shared states, direction codes and sizing helper for the
//                shift-register sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package srctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_sequencer.sv
// ============================================================================
//  Module      : shift_reg_sequencer
//  Description : Loads a parallel word into a mode/Dr/Dl bidirectional shift
//                register over WIDTH clocks, then captures q and pulses done.
//                Optional capture check enabled by macro SRCTRL_VERIFY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_sequencer
  import srctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             dir,
  input  logic [WIDTH-1:0] data,
  output logic             sr_mode,
  output logic             sr_dr,
  output logic             sr_dl,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mismatch
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_sr_mode;
  logic             r_sr_dr;
  logic             r_sr_dl;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_drive;
  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] w_word;
  logic             w_dirsel;
  logic             w_mode_nxt;
  logic             w_dr_nxt;
  logic             w_dl_nxt;

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign w_accept    = start_valid & start_ready;

  assign sr_mode = r_sr_mode;
  assign sr_dr   = r_sr_dr;
  assign sr_dl   = r_sr_dl;
  assign done    = r_done;
  assign result  = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The serial value driven now is consumed by the register on the next edge,
  // so the sequence position runs one ahead of the bits already shifted in.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_sr_mode;
    w_dr_nxt    = 1'b0;
    w_dl_nxt    = 1'b0;
    w_drive     = 1'b0;
    w_pos       = '0;
    w_word      = r_data;
    w_dirsel    = r_dir;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_word      = data;
          w_dirsel    = dir;
          w_mode_nxt  = dir;
          w_cnt_nxt   = '0;
          w_drive     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_pos     = r_cnt + 1'b1;
          w_drive   = 1'b1;
        end
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_drive) begin
      if (w_dirsel == DIR_RIGHT) w_dr_nxt = w_word[w_pos];
      else                       w_dl_nxt = w_word[LAST - w_pos];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_dir     <= 1'b0;
      r_sr_mode <= 1'b0;
      r_sr_dr   <= 1'b0;
      r_sr_dl   <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_sr_mode <= w_mode_nxt;
      r_sr_dr   <= w_dr_nxt;
      r_sr_dl   <= w_dl_nxt;
      r_done    <= (r_state == CAPTURE);
      if (w_accept) begin
        r_data <= data;
        r_dir  <= dir;
      end
      if (r_state == CAPTURE) begin
        r_result <= sr_q;
      end
    end
  end

`ifdef SRCTRL_VERIFY_EN
  logic r_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= (r_state == CAPTURE) && (sr_q != r_data);
    end
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_sequencer.sv
// ============================================================================
//  Module      : tb_shift_reg_sequencer
//  Description : Scoreboard bench for shift_reg_sequencer driving a behavioural
//                bidirectional shift register; honours SRCTRL_VERIFY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_sequencer;
  import srctrl_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] word;
    logic         dir;
    logic         inj;
    int           acc;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic         dir = 1'b0;
  logic [W-1:0] data = '0;
  logic         sr_mode, sr_dr, sr_dl;
  logic [W-1:0] sr_q;
  logic         busy, done, mismatch;
  logic [W-1:0] result;

  logic [W-1:0] r_q = '0;
  logic         inj_now = 1'b0;
  logic         inj_req = 1'b0;

  txn_t sb[$];
  int   cyc = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  int   total = 0;
  int   bad = 0;

  shift_reg_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .dir        (dir),
    .data       (data),
    .sr_mode    (sr_mode),
    .sr_dr      (sr_dr),
    .sr_dl      (sr_dl),
    .sr_q       (sr_q),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  // Bidirectional register load (no reset, no hold).
  always_ff @(posedge clk) begin
    if (sr_mode == 1'b0) r_q <= {sr_dr, r_q[W-1:1]};
    else                 r_q <= {r_q[W-2:0], sr_dl};
  end
  assign sr_q = r_q ^ (inj_now ? W'(4'b0100) : '0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard push: a request is taken whenever no word is outstanding.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start_valid && sb.size() == 0) begin
      sb.push_back('{word: data, dir: dir, inj: inj_req, acc: cyc});
      n_acc++;
      last_acc = cyc;
    end
  end

  // Monitor: j counts edges since accept; bit j is presented for edge j+1.
  always @(negedge clk) begin
    txn_t t;
    int   j;
    logic b;
    logic [W-1:0] exp_res;
    logic         exp_mm;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", start_ready, 1);
      chk("rst_sr", {sr_mode, sr_dr, sr_dl}, 0);
      chk("rst_result", result, 0);
      chk("rst_mismatch", mismatch, 0);
    end else if (sb.size() == 0) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ready", start_ready, 1);
      chk("idle_serial", {sr_dr, sr_dl}, 0);
      chk("idle_mismatch", mismatch, 0);
    end else begin
      t = sb[0];
      j = cyc - t.acc;
      if (j < W) begin
        b = (t.dir == DIR_LEFT) ? t.word[W-1-j] : t.word[j];
        chk("shift_busy", busy, 1);
        chk("shift_ready", start_ready, 0);
        chk("shift_done", done, 0);
        chk("shift_mode", sr_mode, t.dir);
        chk("shift_serial", {sr_dr, sr_dl}, (t.dir == DIR_LEFT) ? {1'b0, b} : {b, 1'b0});
      end else if (j == W) begin
        chk("cap_busy", busy, 1);
        chk("cap_done", done, 0);
        chk("cap_serial", {sr_dr, sr_dl}, 0);
        chk("reg_loaded", r_q, t.word);
        inj_now = t.inj;
      end else begin
        inj_now = 1'b0;
        exp_res = t.inj ? (t.word ^ W'(4'b0100)) : t.word;
`ifdef SRCTRL_VERIFY_EN
        exp_mm = t.inj;
`else
        exp_mm = 1'b0;
`endif
        chk("done_pulse", done, 1);
        chk("done_result", result, exp_res);
        chk("done_mismatch", mismatch, exp_mm);
        chk("done_busy", busy, 0);
        chk("done_ready", start_ready, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 50 && n_acc < target; i++) tick();
    if (n_acc < target) chk("accept_timeout", n_acc, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) chk("idle_timeout", sb.size(), 0);
  endtask

  task automatic send(input logic [W-1:0] w, input logic d, input logic inj, input bit noisy);
    start_valid = 1'b1;
    data        = w;
    dir         = d;
    inj_req     = inj;
    wait_acc(n_acc + 1);
    inj_req = 1'b0;
    if (noisy) begin
      for (int i = 0; i < W; i++) begin
        data = W'($urandom);
        dir  = 1'($urandom);
        tick();
      end
    end
    start_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int a1;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    // Reset held with a pending request: nothing may be accepted.
    start_valid = 1'b1;
    data        = 4'b1010;
    dir         = 1'b0;
    repeat (3) tick();
    chk("no_accept_in_reset", n_acc, 0);
    rst_n = 1'b1;
    wait_acc(1);
    start_valid = 1'b0;
    wait_idle();

    send(4'b1101, 1'b1, 1'b0, 1'b0);

    // Back-to-back with data changed during the first transfer.
    start_valid = 1'b1;
    data        = 4'b0011;
    dir         = 1'b0;
    wait_acc(n_acc + 1);
    a1   = last_acc;
    data = 4'b1100;
    wait_acc(n_acc + 1);
    start_valid = 1'b0;
    chk("b2b_gap", last_acc - a1, W + 2);
    wait_idle();

    // Reset after two bits have been consumed.
    start_valid = 1'b1;
    data        = 4'b1011;
    dir         = 1'b1;
    wait_acc(n_acc + 1);
    start_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    sb.delete();
    inj_now = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sr", {sr_mode, sr_dr, sr_dl}, 0);
    chk("midrst_result", result, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send(4'b0110, 1'b0, 1'b0, 1'b0);

    // Corrupted capture, then a clean one.
    send(4'b0101, 1'b0, 1'b1, 1'b0);
    send(4'b0101, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    wait_idle();
    chk("final_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
